lfsr_stream_engine: RTL
=======================

Name: lfsr_stream_engine

Overview:
- Parametrised successor to the single-bit LFSR random engine datapath: a programmable-width LFSR plus its own controller.
- Supports runtime-selectable Fibonacci or Galois feedback and packs OUT_BITS successive LFSR output bits into a word.
- Delivers words over a valid/ready stream, with a programmable word count and all-zero lockup recovery.
- Sits between the configuration front-end and any consumer needing pseudo-random words.

Parameters:
WIDTH, 8, LFSR state width in bits (>= 2)
OUT_BITS, 8, output bits packed per word (>= 1)
COUNT_W, 16, width of word-count field

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cfg_val  input  1  configuration request valid
cfg_rdy  output  1  engine accepts configuration (IDLE only)
cfg_tap  input  WIDTH  feedback tap mask
cfg_seed  input  WIDTH  initial LFSR state
cfg_galois  input  1  0 = Fibonacci, 1 = Galois
cfg_count  input  COUNT_W  words to produce; 0 = free-running
stop  input  1  abort current run
out_val  output  1  output word valid
out_rdy  input  1  consumer ready
out_data  output  OUT_BITS  packed random word
busy  output  1  high in FILL or STREAM
lockup  output  1  sticky: zero seed substituted or zero-state recovery occurred

Behaviour:
- Single clock domain. rst is synchronous and active-high. On rst: FSM=IDLE, lfsr=0, out_val=0, out_data=0, busy=0, lockup=0, bit counter=0, remaining=0. cfg_rdy=0 during any cycle with rst high.
- FSM states: IDLE, FILL, STREAM.
- IDLE:
  - cfg_rdy=1.
  - On cfg_val: latch tap, seed, mode and count; lfsr<=seed; clear lockup; bit counter<=0; go to FILL.
  - If cfg_seed==0: load 1 instead and set lockup.
- LFSR step, performed once per FILL cycle:
  - out_bit = lfsr[0].
  - Fibonacci: fb = XOR-reduce(lfsr & tap); next = {fb, lfsr[WIDTH-1:1]}.
  - Galois: next = (lfsr >> 1) ^ (lfsr[0] ? tap : 0).
  - Word shift: word <= {out_bit, word[OUT_BITS-1:1]}. After OUT_BITS steps, the first generated bit is at out_data[0].
- Lockup recovery: if next==0, load the latched seed (substituted value) instead and set lockup. lockup stays set until the next accepted cfg or rst.
- FILL: after exactly OUT_BITS step cycles, go to STREAM with out_val=1. A word therefore appears OUT_BITS cycles after cfg acceptance.
- STREAM:
  - out_val=1; out_data and lfsr hold stable until out_rdy=1.
  - On handshake with count==0 (free-running): return to FILL.
  - On handshake with count!=0: remaining decrements. If the decremented value is 0, go to IDLE; else go to FILL.
  - Throughput is at most one word per OUT_BITS+1 cycles.
- stop:
  - In FILL or STREAM: next state IDLE; out_val=0 next cycle; any pending word is discarded with no handshake. A stop in the same cycle as a STREAM handshake still counts that word as transferred.
  - lfsr and lockup retain their values.
  - In IDLE: stop has priority over cfg_val; the configuration is not accepted.
- cfg_val outside IDLE is ignored; cfg_rdy=0.
- out_data holds the last word after returning to IDLE; out_val=0.
- busy = (state != IDLE).
- All arithmetic is unsigned. The remaining-count wrap is impossible because count==0 means free-running.

Test Plan:
- WIDTH=8, OUT_BITS=8, Fibonacci, tap=0x01, seed=0xA5, count=2, out_rdy=1 -> two words 0xA5, 0xA5. Each out_val asserts 8 cycles after acceptance / previous handshake. Then IDLE with cfg_rdy=1, busy=0, lockup=0.
- Galois, tap=0xB8, seed=0x01, count=1 -> out_data=0x71, lfsr=0x64 afterwards, lockup=0.
- Galois, tap=0x00, seed=0xA5, count=2 -> step 8 next-state would be 0, so the seed is reloaded. Words 0xA5, 0xA5; lockup=1 from that cycle onward.
- cfg_seed=0x00, Fibonacci, tap=0x01, count=1 -> seed 0x01 substituted, lockup=1 in the cycle after acceptance, word 0x01.
- Backpressure: count=0, out_rdy=0 for 5 cycles while out_val=1 -> out_data and lfsr constant. out_rdy=1 -> handshake, FILL resumes, next word after 8 cycles.
- stop asserted on cycle 3 of FILL -> IDLE next cycle with no out_val. A new cfg_val with count=1 is accepted and produces 1 word. rst asserted mid-STREAM -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/lfsr_stream_if.sv
// lfsr_stream_if: configuration and output stream signals of the LFSR stream engine
interface lfsr_stream_if #(
  parameter int WIDTH = 8,
  parameter int OUT_BITS = 8,
  parameter int COUNT_W = 16
);
   logic cfg_val;
   logic cfg_rdy;
   logic [WIDTH-1:0] cfg_tap;
   logic [WIDTH-1:0] cfg_seed;
   logic cfg_galois;
   logic [COUNT_W-1:0] cfg_count;
   logic stop;
   logic out_val;
   logic out_rdy;
   logic [OUT_BITS-1:0] out_data;
   logic busy;
   logic lockup;
   modport master (
      output cfg_val, cfg_tap, cfg_seed, cfg_galois, cfg_count, stop, out_rdy,
      input  cfg_rdy, out_val, out_data, busy, lockup
   );
   modport slave (
      input  cfg_val, cfg_tap, cfg_seed, cfg_galois, cfg_count, stop, out_rdy,
      output cfg_rdy, out_val, out_data, busy, lockup
   );
endinterface

// File: rtl/lfsr_stream_engine.sv
// lfsr_stream_engine: Fibonacci/Galois LFSR packing OUT_BITS output bits per word onto a valid/ready stream
module lfsr_stream_engine #(
   parameter int WIDTH = 8,
   parameter int OUT_BITS = 8,
   parameter int COUNT_W = 16
) (
   input logic clk,
   input logic rst,
   lfsr_stream_if.slave bus
);
   localparam int BC_W = $clog2(OUT_BITS + 1);
   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] lfsr, tap, seed, step, lfsr_n;
   logic galois, lockup, last_bit, accept;
   logic [COUNT_W-1:0] remaining;
   logic [BC_W-1:0] bit_cnt;
   logic [OUT_BITS-1:0] word;
   assign accept = state == IDLE && bus.cfg_val && !bus.stop;
   assign bus.cfg_rdy = state == IDLE && !rst;
   assign bus.out_val = state == STREAM;
   assign bus.busy = state != IDLE;
   assign bus.out_data = word;
   assign bus.lockup = lockup;
   always_comb begin
      step = galois ? (lfsr >> 1) ^ (lfsr[0] ? tap : '0) : {^(lfsr & tap), lfsr[WIDTH-1:1]};
      lfsr_n = step == '0 ? seed : step;
      last_bit = bit_cnt == BC_W'(OUT_BITS - 1);
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? FILL : IDLE;
         FILL:    state_n = bus.stop ? IDLE : last_bit ? STREAM : FILL;
         // remaining==0 marks a free-running run, ==1 the final counted word
         STREAM:  state_n = bus.stop ? IDLE : !bus.out_rdy ? STREAM : remaining == COUNT_W'(1) ? IDLE : FILL;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         lfsr <= '0;
         tap <= '0;
         seed <= '0;
         galois <= 1'b0;
         lockup <= 1'b0;
         remaining <= '0;
         bit_cnt <= '0;
         word <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            tap <= bus.cfg_tap;
            seed <= bus.cfg_seed == '0 ? WIDTH'(1) : bus.cfg_seed;
            lfsr <= bus.cfg_seed == '0 ? WIDTH'(1) : bus.cfg_seed;
            galois <= bus.cfg_galois;
            remaining <= bus.cfg_count;
            lockup <= bus.cfg_seed == '0;
            bit_cnt <= '0;
         end
         if (state == FILL && !bus.stop) begin
            lfsr <= lfsr_n;
            lockup <= lockup | (step == '0);
            word <= (word >> 1) | (OUT_BITS'(lfsr[0]) << (OUT_BITS - 1));
            bit_cnt <= last_bit ? '0 : bit_cnt + BC_W'(1);
         end
         if (state == STREAM && bus.out_rdy && remaining != '0)
            remaining <= remaining - COUNT_W'(1);
      end
   end
endmodule
